assoc_cache: RTL and testbench
==============================

ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 Parameter ADDR_W, default 16, word-address width.
REQ-002 Parameter DATA_W, default 16, word width.
REQ-003 Parameter WORDS, default 4, words per line; power of 2, at least 2.
REQ-004 Parameter SETS, default 8, set count; power of 2, at least 2.
REQ-005 Parameter WAYS, default 2, associativity; one of 1, 2 or 4.
REQ-006 Derived widths: OFF_W=log2(WORDS), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W, LINE_W=WORDS*DATA_W.
REQ-007 The block SHALL use one clock; reset is synchronous and active-high.
REQ-008 Ports, in order:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cpu_en  in  1  request valid.
- cpu_rd_wrt  in  1  1=read, 0=write.
- cpu_addr  in  ADDR_W  {tag, index, offset}, offset in the LSBs.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_hit  out  1  valid with cpu_done; 1 = the access hit.
- mem_req  out  1  memory request.
- mem_we  out  1  1=writeback, 0=fill.
- mem_addr  out  ADDR_W-OFF_W  line address.
- mem_wdata  out  LINE_W  writeback line.
- mem_rdata  in  LINE_W  fill line.
- mem_rdy  in  1  memory completion, sampled only while mem_req=1.

Function
REQ-009 Each line SHALL hold valid, dirty, tag and data; word k SHALL occupy data bits [k*DATA_W +: DATA_W].
REQ-010 The cache SHALL be write-back and write-allocate.
REQ-011 The FSM SHALL have states IDLE, WB, FILL and RESP; all outputs SHALL be registered.
REQ-012 In IDLE with cpu_en=1:
- hit on a read: cpu_rdata gets the addressed word.
- hit on a write: the word is updated and dirty is set.
- either hit: cpu_hit=1, next state RESP.
REQ-013 In IDLE on a miss:
- victim valid and dirty: next state WB.
- otherwise: next state FILL.
REQ-014 Victim selection SHALL pick the lowest-numbered invalid way if one exists, else the way given by a per-set round-robin pointer.
REQ-015 After a fill into way w, the pointer SHALL become (w+1) mod WAYS; hits SHALL NOT move it.
REQ-016 In WB:
- mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim line.
- On mem_rdy=1, next state FILL.
REQ-017 In FILL:
- mem_req=1, mem_we=0, mem_addr={req tag, index}.
- On mem_rdy=1: install mem_rdata into the victim way, set tag and valid=1.
- The access SHALL then complete from the new line: a read returns the addressed word; a write merges cpu_wdata and sets dirty=1.
- cpu_hit=0; next state RESP.
REQ-018 mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable until mem_rdy is sampled high.
REQ-019 mem_req SHALL drop in the cycle after acceptance when going from FILL to RESP; going from WB to FILL it stays high.
REQ-020 In RESP, cpu_done=1 for exactly one cycle, cpu_en is ignored, and the next state is IDLE.
REQ-021 Latency:
- hit: done 1 cycle after the request edge; throughput one access per 2 cycles.
- miss: done 1 cycle after the final mem_rdy.
REQ-022 The requester SHALL hold cpu_addr, cpu_rd_wrt and cpu_wdata stable until cpu_done; the block samples them in every state.
REQ-023 With WAYS=1, the victim SHALL always be way 0 and no pointer logic is needed.

Reset
REQ-024 With rst=1 at a clock edge:
- state=IDLE.
- All valid, dirty and pointer bits are cleared.
- cpu_rdata=0, cpu_done=0, cpu_hit=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-025 Reset during WB or FILL SHALL abort the transaction: mem_req is low in the cycle after the reset edge, no line is installed, and no done pulse occurs.

Structure
REQ-026 A shared package cache_pkg SHALL hold the state enum and the width functions for OFF_W, IDX_W and TAG_W.
REQ-027 Victim selection (invalid-first plus round-robin pointers) SHALL be the sub-module cache_victim_sel.

Verification (defaults; mem_rdy single-cycle unless stated)
REQ-028 Cold read miss:
- Stimulus: reset, read 0x0012; in FILL return mem_rdata=0x4444_3333_2222_1111.
- Response: mem_addr=0x0004, mem_we=0; then cpu_rdata=0x3333, cpu_hit=0, one done pulse.
REQ-029 Read hit:
- Stimulus: after REQ-028, read 0x0013.
- Response: done 1 cycle after the request, cpu_rdata=0x4444, cpu_hit=1, mem_req stays 0.
REQ-030 Dirty eviction:
- Stimulus: write 0xBEEF to 0x0010 (hit), read miss 0x0030 (fills way1), read miss 0x0050.
- Response: WB with mem_we=1, mem_addr=0x0004, mem_wdata[15:0]=0xBEEF; then FILL with mem_addr=0x0014.
REQ-031 Write miss:
- Stimulus: write 0xA5A5 to 0x0101; fill returns all zeros.
- Response: no WB; a later read of 0x0101 hits with 0xA5A5; evicting that line writes it back.
REQ-032 Slow memory and reset:
- Stimulus: hold mem_rdy low for 5 cycles in FILL.
- Response: mem_req and mem_addr stay stable and done stays 0.
- Stimulus: then assert rst.
- Response: mem_req=0 next cycle; re-reading the same address misses.
REQ-033 WAYS=4, SETS=2:
- Stimulus: read misses to 5 distinct tags in set 0.
- Response: the 5th fill replaces way 0; the way-1 tag still hits.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative cache.
// Contents: controller state enum and the offset/index/tag/way width functions.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } state_e;

  // Word-offset width inside a line.
  function automatic int unsigned off_w(input int unsigned words);
    return $clog2(words);
  endfunction

  // Set-index width.
  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  // Tag width: whatever is left of the word address.
  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned sets,
                                        input int unsigned words);
    return addr_w - $clog2(sets) - $clog2(words);
  endfunction

  // Way-number width; a direct-mapped cache still carries one bit.
  function automatic int unsigned way_w(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Replacement victim selection: lowest invalid way first, otherwise the
// per-set round-robin pointer. Pointers advance only on a line fill.
// Ports:
//   clk, rst      clock and synchronous active-high reset (clears pointers)
//   set_idx       set being looked up (also the set a fill updates)
//   set_valid     valid bits of that set, one per way
//   upd_en        a fill completes this cycle
//   upd_way       way that was filled
//   victim_way_c  combinational victim way for set_idx
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int unsigned SETS = 8,
  parameter int unsigned WAYS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [idx_w(SETS)-1:0]     set_idx,
  input  logic [WAYS-1:0]            set_valid,
  input  logic                       upd_en,
  input  logic [way_w(WAYS)-1:0]     upd_way,
  output logic [way_w(WAYS)-1:0]     victim_way_c
);

  localparam int unsigned WAY_W = way_w(WAYS);

  if (WAYS == 1) begin : g_direct
    // Direct-mapped: the only way is always the victim.
    assign victim_way_c = '0;
  end else begin : g_rr
    logic [WAY_W-1:0] ptr_q [SETS];
    logic             found;

    // Round-robin pointers: next way after the one just filled.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < int'(SETS); s++) begin
          ptr_q[s] <= '0;
        end
      end else if (upd_en) begin
        ptr_q[set_idx] <= (upd_way == WAY_W'(WAYS - 1)) ? '0 : upd_way + WAY_W'(1);
      end
    end

    // Invalid ways take priority, lowest number first.
    always_comb begin
      found        = 1'b0;
      victim_way_c = ptr_q[set_idx];
      for (int w = 0; w < int'(WAYS); w++) begin
        if (!found && !set_valid[WAY_W'(w)]) begin
          found        = 1'b1;
          victim_way_c = WAY_W'(w);
        end
      end
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// Set-associative, write-back, write-allocate cache with a single line-wide
// memory port. One access at a time: hits complete in the response cycle after
// the request edge, misses go through an optional writeback then a fill.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cpu_en, cpu_rd_wrt             request valid, 1=read 0=write
//   cpu_addr, cpu_wdata            word address {tag,index,offset}, write data
//   cpu_rdata, cpu_done, cpu_hit   read data, one-cycle completion, hit flag
//   mem_req, mem_we                memory request, 1=writeback 0=fill
//   mem_addr, mem_wdata            line address, writeback line
//   mem_rdata, mem_rdy             fill line, memory completion
module assoc_cache
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned SETS   = 8,
  parameter int unsigned WAYS   = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cpu_en,
  input  logic                               cpu_rd_wrt,
  input  logic [ADDR_W-1:0]                  cpu_addr,
  input  logic [DATA_W-1:0]                  cpu_wdata,
  output logic [DATA_W-1:0]                  cpu_rdata,
  output logic                               cpu_done,
  output logic                               cpu_hit,
  output logic                               mem_req,
  output logic                               mem_we,
  output logic [ADDR_W-off_w(WORDS)-1:0]     mem_addr,
  output logic [WORDS*DATA_W-1:0]            mem_wdata,
  input  logic [WORDS*DATA_W-1:0]            mem_rdata,
  input  logic                               mem_rdy
);

  localparam int unsigned OFF_W   = off_w(WORDS);
  localparam int unsigned IDX_W   = idx_w(SETS);
  localparam int unsigned TAG_W   = tag_w(ADDR_W, SETS, WORDS);
  localparam int unsigned LINE_W  = WORDS * DATA_W;
  localparam int unsigned WAY_W   = way_w(WAYS);
  localparam int unsigned MADDR_W = ADDR_W - OFF_W;

  state_e state_q, state_d;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [31:0]       word_lsb;

  logic              hit_c;
  logic [WAY_W-1:0]  hit_way_c;
  logic [WAY_W-1:0]  vict_way_c, vict_way_q, vict_way_d;
  logic              vict_dirty_c;
  logic [LINE_W-1:0] hit_line_c, vict_line_c, fill_line_c;
  logic [TAG_W-1:0]  vict_tag_c;
  logic              hit_wr_c, fill_done_c;

  logic [DATA_W-1:0]  rdata_d;
  logic               done_d, hit_d, req_d, we_d;
  logic [MADDR_W-1:0] maddr_d;
  logic [LINE_W-1:0]  mwdata_d;

  // Request fields; the requester holds them until done.
  assign req_off  = cpu_addr[OFF_W-1:0];
  assign req_idx  = cpu_addr[OFF_W +: IDX_W];
  assign req_tag  = cpu_addr[ADDR_W-1 -: TAG_W];
  assign word_lsb = 32'(req_off) * DATA_W;

  // Tag lookup across the ways of the addressed set.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (!hit_c && valid_q[req_idx][WAY_W'(w)] && (tag_q[req_idx][WAY_W'(w)] == req_tag)) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
    end
  end

  cache_victim_sel #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_victim_sel (
    .clk          (clk),
    .rst          (rst),
    .set_idx      (req_idx),
    .set_valid    (valid_q[req_idx]),
    .upd_en       (fill_done_c),
    .upd_way      (vict_way_q),
    .victim_way_c (vict_way_c)
  );

  assign hit_line_c   = data_q[req_idx][hit_way_c];
  assign vict_line_c  = data_q[req_idx][vict_way_c];
  assign vict_tag_c   = tag_q[req_idx][vict_way_c];
  assign vict_dirty_c = valid_q[req_idx][vict_way_c] & dirty_q[req_idx][vict_way_c];

  assign hit_wr_c    = (state_q == IDLE) && cpu_en && hit_c && !cpu_rd_wrt;
  assign fill_done_c = (state_q == FILL) && mem_rdy;

  // Fill line with a pending write merged in, so a write miss completes in place.
  always_comb begin
    fill_line_c = mem_rdata;
    if (!cpu_rd_wrt) begin
      fill_line_c[word_lsb +: DATA_W] = cpu_wdata;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_en) begin
          if (hit_c)             state_d = RESP;
          else if (vict_dirty_c) state_d = WB;
          else                   state_d = FILL;
        end
      end
      WB:      if (mem_rdy) state_d = FILL;
      FILL:    if (mem_rdy) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; memory signals hold until accepted.
  always_comb begin
    rdata_d    = cpu_rdata;
    done_d     = 1'b0;
    hit_d      = cpu_hit;
    req_d      = mem_req;
    we_d       = mem_we;
    maddr_d    = mem_addr;
    mwdata_d   = mem_wdata;
    vict_way_d = vict_way_q;
    case (state_q)
      IDLE: begin
        if (cpu_en) begin
          if (hit_c) begin
            done_d = 1'b1;
            hit_d  = 1'b1;
            if (cpu_rd_wrt) rdata_d = hit_line_c[word_lsb +: DATA_W];
          end else begin
            vict_way_d = vict_way_c;
            req_d      = 1'b1;
            if (vict_dirty_c) begin
              we_d     = 1'b1;
              maddr_d  = {vict_tag_c, req_idx};
              mwdata_d = vict_line_c;
            end else begin
              we_d    = 1'b0;
              maddr_d = {req_tag, req_idx};
            end
          end
        end
      end
      WB: begin
        if (mem_rdy) begin
          we_d    = 1'b0;
          maddr_d = {req_tag, req_idx};
        end
      end
      FILL: begin
        if (mem_rdy) begin
          req_d  = 1'b0;
          done_d = 1'b1;
          hit_d  = 1'b0;
          if (cpu_rd_wrt) rdata_d = mem_rdata[word_lsb +: DATA_W];
        end
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata  <= '0;
      cpu_done   <= 1'b0;
      cpu_hit    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      vict_way_q <= '0;
    end else begin
      cpu_rdata  <= rdata_d;
      cpu_done   <= done_d;
      cpu_hit    <= hit_d;
      mem_req    <= req_d;
      mem_we     <= we_d;
      mem_addr   <= maddr_d;
      mem_wdata  <= mwdata_d;
      vict_way_q <= vict_way_d;
    end
  end

  // Line state bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      if (hit_wr_c) begin
        dirty_q[req_idx][hit_way_c] <= 1'b1;
      end
      if (fill_done_c) begin
        valid_q[req_idx][vict_way_q] <= 1'b1;
        dirty_q[req_idx][vict_way_q] <= !cpu_rd_wrt;
      end
    end
  end

  // Tag and data arrays; no reset needed since valid gates every use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (hit_wr_c) begin
        data_q[req_idx][hit_way_c][word_lsb +: DATA_W] <= cpu_wdata;
      end
      if (fill_done_c) begin
        data_q[req_idx][vict_way_q] <= fill_line_c;
        tag_q[req_idx][vict_way_q]  <= req_tag;
      end
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache: default 2-way instance plus a 4-way/2-set one.
module tb_assoc_cache;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // Default instance
  logic        cpu_en, cpu_rd_wrt;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_done, cpu_hit, mem_req, mem_we, mem_rdy;
  logic [13:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  // 4-way instance
  logic        cpu_en2, cpu_rd_wrt2;
  logic [15:0] cpu_addr2, cpu_wdata2, cpu_rdata2;
  logic        cpu_done2, cpu_hit2, mem_req2, mem_we2, mem_rdy2;
  logic [13:0] mem_addr2;
  logic [63:0] mem_wdata2, mem_rdata2;

  assoc_cache u_dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_rd_wrt(cpu_rd_wrt),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done), .cpu_hit(cpu_hit), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  assoc_cache #(.WAYS(4), .SETS(2)) u_dut4 (
    .clk(clk), .rst(rst), .cpu_en(cpu_en2), .cpu_rd_wrt(cpu_rd_wrt2),
    .cpu_addr(cpu_addr2), .cpu_wdata(cpu_wdata2), .cpu_rdata(cpu_rdata2),
    .cpu_done(cpu_done2), .cpu_hit(cpu_hit2), .mem_req(mem_req2), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_rdy(mem_rdy2)
  );

  typedef struct { logic hit; logic [15:0] rdata; logic rd; } exp_t;
  typedef struct { logic we; logic [13:0] addr; logic [63:0] wdata; } txn_t;

  exp_t        sb_q[$];
  txn_t        obs_q[$];
  logic [63:0] mem_img [logic [13:0]];
  int          n_cmp = 0;
  int          n_err = 0;
  int          rdy_delay = 0;

  // Which instance the access task talks to.
  logic        sel2 = 1'b0;
  logic        done_s, hit_s, mreq_s;
  logic [15:0] rdata_s;
  assign done_s  = sel2 ? cpu_done2  : cpu_done;
  assign hit_s   = sel2 ? cpu_hit2   : cpu_hit;
  assign mreq_s  = sel2 ? mem_req2   : mem_req;
  assign rdata_s = sel2 ? cpu_rdata2 : cpu_rdata;

  // Untouched memory lines read back as their line address in every word.
  function automatic logic [63:0] line_pat(input logic [13:0] a);
    return {4{2'b00, a}};
  endfunction

  // Memory model for the default instance, logging each accepted transfer.
  initial begin : resp1
    int cnt;
    cnt = 0;
    mem_rdy = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !mem_req || mem_rdy) begin
        mem_rdy = 1'b0;
        cnt = 0;
      end else if (cnt >= rdy_delay) begin
        mem_rdy = 1'b1;
        obs_q.push_back('{mem_we, mem_addr, mem_wdata});
        if (mem_we) mem_img[mem_addr] = mem_wdata;
        else mem_rdata = mem_img.exists(mem_addr) ? mem_img[mem_addr] : line_pat(mem_addr);
      end else begin
        cnt++;
      end
    end
  end

  // Memory model for the 4-way instance: single-cycle, pattern data only.
  initial begin : resp2
    mem_rdy2 = 1'b0;
    mem_rdata2 = '0;
    forever begin
      @(negedge clk);
      if (rst || !mem_req2 || mem_rdy2) begin
        mem_rdy2 = 1'b0;
      end else begin
        mem_rdy2 = 1'b1;
        mem_rdata2 = line_pat(mem_addr2);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // One CPU access: push the expectation, drive, wait (bounded) for done, compare.
  task automatic access(input logic d2, input logic rd, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic exp_hit,
                        input logic [15:0] exp_rdata, input string name);
    exp_t e;
    int   n;
    e.hit = exp_hit;
    e.rdata = exp_rdata;
    e.rd = rd;
    sb_q.push_back(e);
    sel2 = d2;
    @(negedge clk);
    if (d2) begin
      cpu_en2 = 1'b1; cpu_rd_wrt2 = rd; cpu_addr2 = addr; cpu_wdata2 = wdata;
    end else begin
      cpu_en = 1'b1; cpu_rd_wrt = rd; cpu_addr = addr; cpu_wdata = wdata;
    end
    @(negedge clk);
    cpu_en = 1'b0;
    cpu_en2 = 1'b0;
    n = 0;
    while (!done_s && n < 200) begin
      @(negedge clk);
      n++;
    end
    e = sb_q.pop_front();
    check({name, " done"}, 64'(done_s), 64'd1);
    if (done_s) begin
      check({name, " hit"}, 64'(hit_s), 64'(e.hit));
      if (e.rd) check({name, " rdata"}, 64'(rdata_s), 64'(e.rdata));
      if (e.hit) begin
        check({name, " hit latency"}, 64'(n), 64'd0);
        check({name, " no mem_req"}, 64'(mreq_s), 64'd0);
      end
      @(negedge clk);
      check({name, " done pulse width"}, 64'(done_s), 64'd0);
    end
  endtask

  task automatic expect_txn(input string name, input logic we, input logic [13:0] addr,
                            input logic [63:0] wdata);
    txn_t t;
    check({name, " txn present"}, 64'(obs_q.size() > 0), 64'd1);
    if (obs_q.size() > 0) begin
      t = obs_q.pop_front();
      check({name, " mem_we"}, 64'(t.we), 64'(we));
      check({name, " mem_addr"}, 64'(t.addr), 64'(addr));
      if (we) check({name, " mem_wdata"}, t.wdata, wdata);
    end
  endtask

  task automatic expect_no_txn(input string name);
    check({name, " extra txn"}, 64'(obs_q.size()), 64'd0);
    obs_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    cpu_en = 1'b0; cpu_rd_wrt = 1'b1; cpu_addr = '0; cpu_wdata = '0;
    cpu_en2 = 1'b0; cpu_rd_wrt2 = 1'b1; cpu_addr2 = '0; cpu_wdata2 = '0;
    repeat (3) @(negedge clk);
    check("rst cpu_rdata", 64'(cpu_rdata), 64'd0);
    check("rst cpu_done",  64'(cpu_done),  64'd0);
    check("rst cpu_hit",   64'(cpu_hit),   64'd0);
    check("rst mem_req",   64'(mem_req),   64'd0);
    check("rst mem_we",    64'(mem_we),    64'd0);
    check("rst mem_addr",  64'(mem_addr),  64'd0);
    check("rst mem_wdata", mem_wdata,      64'd0);
    rst = 1'b0;

    // Cold read miss then hit in the same line.
    mem_img[14'h0004] = 64'h4444_3333_2222_1111;
    access(1'b0, 1'b1, 16'h0012, 16'h0, 1'b0, 16'h3333, "cold miss");
    expect_txn("cold miss fill", 1'b0, 14'h0004, 64'h0);
    expect_no_txn("cold miss");
    access(1'b0, 1'b1, 16'h0013, 16'h0, 1'b1, 16'h4444, "read hit");
    expect_no_txn("read hit");

    // Dirty eviction through round-robin.
    access(1'b0, 1'b0, 16'h0010, 16'hBEEF, 1'b1, 16'h0, "write hit");
    expect_no_txn("write hit");
    access(1'b0, 1'b1, 16'h0030, 16'h0, 1'b0, 16'h000C, "miss way1");
    expect_txn("miss way1 fill", 1'b0, 14'h000C, 64'h0);
    expect_no_txn("miss way1");
    access(1'b0, 1'b1, 16'h0050, 16'h0, 1'b0, 16'h0014, "dirty evict");
    expect_txn("dirty evict wb", 1'b1, 14'h0004, 64'h4444_3333_2222_BEEF);
    expect_txn("dirty evict fill", 1'b0, 14'h0014, 64'h0);
    expect_no_txn("dirty evict");
    access(1'b0, 1'b1, 16'h0010, 16'h0, 1'b0, 16'hBEEF, "reload written back");
    expect_txn("reload fill", 1'b0, 14'h0004, 64'h0);
    expect_no_txn("reload");

    // Write miss allocates, merges, and later writes back.
    mem_img[14'h0040] = 64'h0;
    access(1'b0, 1'b0, 16'h0101, 16'hA5A5, 1'b0, 16'h0, "write miss");
    expect_txn("write miss fill", 1'b0, 14'h0040, 64'h0);
    expect_no_txn("write miss");
    access(1'b0, 1'b1, 16'h0101, 16'h0, 1'b1, 16'hA5A5, "write miss readback");
    access(1'b0, 1'b1, 16'h0121, 16'h0, 1'b0, 16'h0048, "set0 second way");
    expect_txn("set0 second fill", 1'b0, 14'h0048, 64'h0);
    access(1'b0, 1'b1, 16'h0141, 16'h0, 1'b0, 16'h0050, "evict write-miss line");
    expect_txn("evict wm wb", 1'b1, 14'h0040, 64'h0000_0000_A5A5_0000);
    expect_txn("evict wm fill", 1'b0, 14'h0050, 64'h0);
    expect_no_txn("evict wm");

    // Stalled fill, then reset aborts it.
    rdy_delay = 1000;
    sel2 = 1'b0;
    @(negedge clk);
    cpu_en = 1'b1; cpu_rd_wrt = 1'b1; cpu_addr = 16'h0200;
    @(negedge clk);
    cpu_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall mem_req",  64'(mem_req),  64'd1);
      check("stall mem_addr", 64'(mem_addr), 64'h0080);
      check("stall mem_we",   64'(mem_we),   64'd0);
      check("stall done",     64'(cpu_done), 64'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort mem_req", 64'(mem_req),  64'd0);
    check("abort done",    64'(cpu_done), 64'd0);
    rst = 1'b0;
    rdy_delay = 0;
    expect_no_txn("abort");
    access(1'b0, 1'b1, 16'h0200, 16'h0, 1'b0, 16'h0080, "reread after abort");
    expect_txn("reread fill", 1'b0, 14'h0080, 64'h0);
    expect_no_txn("reread");

    // 4-way, 2-set: five tags in set 0, the fifth replaces way 0.
    for (int t = 1; t <= 5; t++) begin
      access(1'b1, 1'b1, 16'(t * 8), 16'h0, 1'b0, 16'(t * 2), "4way cold");
    end
    access(1'b1, 1'b1, 16'h0010, 16'h0, 1'b1, 16'h0004, "4way tag2 hit");
    access(1'b1, 1'b1, 16'h0018, 16'h0, 1'b1, 16'h0006, "4way tag3 hit");
    access(1'b1, 1'b1, 16'h0028, 16'h0, 1'b1, 16'h000A, "4way tag5 hit");
    access(1'b1, 1'b1, 16'h0008, 16'h0, 1'b0, 16'h0002, "4way tag1 evicted");
    access(1'b1, 1'b1, 16'h0010, 16'h0, 1'b0, 16'h0004, "4way tag2 evicted");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
